// File: rtl/ula_digit_display.sv
// Two-digit multiplexed seven-segment driver for the ALU digit-pair result.
// Captures units/tens on load, encodes glyphs and alternates common-anode digits.
module ula_digit_display #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] units,
    input  logic [7:0] tens,
    output logic       ack,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    localparam logic [6:0] GLYPH_E     = 7'h79;
    localparam logic [6:0] GLYPH_DASH  = 7'h40;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;
    localparam logic [6:0] GLYPH_ZERO  = 7'h3F;

    localparam logic [1:0] AN_UNITS = 2'b10;
    localparam logic [1:0] AN_TENS  = 2'b01;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            default: g = GLYPH_E;
        endcase
        return g;
    endfunction

    // Full 8-bit compare so any upper bit set falls through to 'E'.
    function automatic logic [6:0] units_glyph(input logic [7:0] v);
        logic [6:0] g;
        if (v > 8'd9) g = GLYPH_E;
        else          g = digit_glyph(v[3:0]);
        return g;
    endfunction

    function automatic logic [6:0] tens_glyph(input logic [7:0] v);
        logic [6:0] g;
        if (v == 8'd0)       g = GLYPH_BLANK;
        else if (v <= 8'd9)  g = digit_glyph(v[3:0]);
        else if (v == 8'd15) g = GLYPH_DASH;
        else                 g = GLYPH_E;
        return g;
    endfunction

    logic [7:0]       u_q, u_d;
    logic [7:0]       t_q, t_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             load_q, load_d;
    logic             ack_q, ack_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;

    // Next-state: capture, refresh timing and registered display outputs.
    always_comb begin
        u_d    = u_q;
        t_d    = t_q;
        cnt_d  = cnt_q + CNT_W'(1);
        sel_d  = sel_q;
        load_d = load;
        ack_d  = load_q;
        seg_d  = sel_q ? tens_glyph(t_q) : units_glyph(u_q);
        an_d   = sel_q ? AN_TENS : AN_UNITS;

        if (load) begin
            u_d = units;
            t_d = tens;
        end

        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            sel_d = ~sel_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u_q    <= '0;
            t_q    <= '0;
            cnt_q  <= '0;
            sel_q  <= 1'b0;
            load_q <= 1'b0;
            ack_q  <= 1'b0;
            seg_q  <= GLYPH_ZERO;
            an_q   <= AN_UNITS;
        end else begin
            u_q    <= u_d;
            t_q    <= t_d;
            cnt_q  <= cnt_d;
            sel_q  <= sel_d;
            load_q <= load_d;
            ack_q  <= ack_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign ack = ack_q;
    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_ula_digit_display.sv
// Scoreboard bench for ula_digit_display with REFRESH_DIV=4: a cycle-indexed
// reference model pushes expected outputs per edge; a checker pops them #1 later.
module tb_ula_digit_display;

    localparam int unsigned DIV = 4;

    typedef struct packed {
        logic [6:0] seg;
        logic [1:0] an;
        logic       ack;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [7:0] units = '0;
    logic [7:0] tens = '0;
    logic       ack;
    logic [6:0] seg;
    logic [1:0] an;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t sb_q[$];

    ula_digit_display #(.REFRESH_DIV(DIV)) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .units (units),
        .tens  (tens),
        .ack   (ack),
        .seg   (seg),
        .an    (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [6:0] digit_tbl [10];
    initial begin
        digit_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    end

    function automatic logic [6:0] exp_units(input logic [7:0] v);
        if (v < 8'd10) return digit_tbl[v];
        return 7'h79;
    endfunction

    function automatic logic [6:0] exp_tens(input logic [7:0] v);
        if (v == 8'd0)  return 7'h00;
        if (v < 8'd10)  return digit_tbl[v];
        if (v == 8'd15) return 7'h40;
        return 7'h79;
    endfunction

    // Reference model: n = edges since reset release; shown digit depends on n alone.
    int         mdl_n = 0;
    logic [7:0] mdl_u = '0;
    logic [7:0] mdl_t = '0;
    logic       mdl_prev_load = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_n = 0;
            mdl_u = '0;
            mdl_t = '0;
            mdl_prev_load = 1'b0;
            sb_q.delete();
        end else begin
            exp_t e;
            logic show_tens;
            mdl_n++;
            show_tens = (((mdl_n - 1) / DIV) % 2) == 1;
            e.seg = show_tens ? exp_tens(mdl_t) : exp_units(mdl_u);
            e.an  = show_tens ? 2'b01 : 2'b10;
            e.ack = mdl_prev_load;
            sb_q.push_back(e);
            mdl_prev_load = load;
            if (load) begin
                mdl_u = units;
                mdl_t = tens;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst) begin
            check("rst_seg", 32'(seg), 32'h3F);
            check("rst_an",  32'(an),  32'h2);
            check("rst_ack", 32'(ack), 32'h0);
        end else if (sb_q.size() == 0) begin
            check("sb_empty", 32'(sb_q.size()), 32'h1);
        end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("seg", 32'(seg), 32'(e.seg));
            check("an",  32'(an),  32'(e.an));
            check("ack", 32'(ack), 32'(e.ack));
            check("an_excl", 32'($countones(~an)), 32'h1);
        end
    end

    task automatic do_load(input logic [7:0] u, input logic [7:0] t);
        @(negedge clk);
        load  = 1'b1;
        units = u;
        tens  = t;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(9);

        do_load(8'd7, 8'd1);
        idle(12);
        do_load(8'd3, 8'd15);
        idle(10);
        do_load(8'd5, 8'd0);
        idle(10);
        do_load(8'd12, 8'd200);
        idle(10);

        // Back-to-back captures with changing data.
        @(negedge clk);
        load = 1'b1; units = 8'd1; tens = 8'd0;
        @(negedge clk);
        units = 8'd2;
        @(negedge clk);
        units = 8'd3;
        @(negedge clk);
        load = 1'b0;
        idle(10);

        // Capture coincident with a refresh wrap.
        for (int guard = 0; guard < 16 && (mdl_n % DIV) != (DIV - 1); guard++) @(negedge clk);
        load = 1'b1; units = 8'd9; tens = 8'd8;
        @(negedge clk);
        load = 1'b0;
        idle(10);

        // Async reset mid-capture: ack pending must be dropped immediately.
        @(negedge clk);
        load = 1'b1; units = 8'd4; tens = 8'd2;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_seg", 32'(seg), 32'h3F);
        check("async_an",  32'(an),  32'h2);
        check("async_ack", 32'(ack), 32'h0);
        @(negedge clk);
        load = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/ula_digit_display.md
# ula_digit_display

Two-digit multiplexed seven-segment driver that consumes the ALU's digit-pair result (units digit plus tens/carry/sign code) and displays it. It captures a result on a load strobe, encodes each digit to segments, and alternates between the two common-anode digits at a programmable refresh rate. It is the display-side consumer of the ALU result bus, between the ALU outputs and the board's segment and anode pins.

## Interface
- REFRESH_DIV, 50000: clock cycles each digit stays enabled; legal range 2..2^20.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  capture strobe; samples units/tens on any rising edge where high.
- units  input  8  units digit from the ALU (valid range 0-9).
- tens  input  8  tens/status code from the ALU: 0-9 digit, 15 = negative sign.
- ack  output  1  registered one-cycle pulse confirming a capture.
- seg  output  7  segment drive, active-high, bit order {g,f,e,d,c,b,a}.
- an  output  2  digit enables, active-low; an[0] = units, an[1] = tens.

## Operation
- Capture registers u_q and t_q (8 bits each) load units and tens on every edge where load=1. Otherwise they hold.
- Refresh counter cnt runs from 0 to REFRESH_DIV-1 and wraps.
- Digit select sel toggles on each wrap: sel=0 shows units, sel=1 shows tens.
- load does not disturb cnt or sel.
- Units encoding: 0-9 map to standard glyphs. Any value >9 shows 'E'.
- Tens encoding:
  - 0 shows blank (leading-zero suppression).
  - 1-9 show standard glyphs.
  - 15 shows '-'.
  - Any other value shows 'E'.
- Glyph codes, hex:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66
  - 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - E=79, '-'=40, blank=00
- an = 2'b10 when sel=0 and 2'b01 when sel=1. Both digits are never enabled together.
- ack = registered copy of load. If load is held high, ack stays high and a capture occurs every cycle.

## Timing
- Reset (asynchronous, immediate on rst rising):
  - u_q, t_q, cnt, sel, ack = 0.
  - an = 2'b10, seg = 7'h3F (units '0' shown).
  - Outputs hold these values while rst=1.
- seg, an and ack are registered. No combinational path exists from any input to any output.
- Capture latency:
  - load high at edge k: u_q/t_q update at edge k.
  - ack is high from edge k+1 to edge k+2.
  - seg reflects the new value for the selected digit from edge k+1.
- Refresh:
  - sel toggles at the edge where cnt goes from REFRESH_DIV-1 to 0.
  - an and seg switch together at the following edge, so the digit and its glyph change in the same cycle.
  - Each digit is lit for exactly REFRESH_DIV cycles per period of 2·REFRESH_DIV.
- Simultaneous load and wrap: both take effect. The newly selected digit shows the newly captured value from the next edge.
- Reset mid-refresh or mid-capture: the state returns to the reset values above. Any pending ack is dropped.
- Widths: cnt width = clog2(REFRESH_DIV). Digit comparisons use the full 8-bit inputs, so upper bits set → 'E' (or blank only for exactly 0 on tens).

## Test plan
All scenarios use REFRESH_DIV=4.
- Reset: assert rst mid-run → seg=3F, an=10, ack=0 immediately. After release, sel toggles first at the 4th edge.
- Load units=7, tens=1 → ack high one cycle. Alternating windows show seg=07/an=10 and seg=06/an=01, each exactly 4 cycles.
- Load units=3, tens=15 → units window seg=4F, tens window seg=40 ('-').
- Load units=5, tens=0 → tens window seg=00 with an=01 (blank, digit still strobed).
- Load units=12, tens=200 → both windows seg=79 ('E').
- load held high 3 cycles with changing data 1/2/3 (tens 0) → ack high 3 cycles, final displayed units seg=4F. Load coincident with a wrap → new digit shows new data one edge later, with no glitch cycle where both anodes are low.
